conv3x3_engine: RTL

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv3x3_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: streaming 3x3 convolution, 8u pixels x 8s coefficients, SHIFT then clamp to 0..255 (CONV3X3_ABS_EN: |neg| instead of 0).
// Latency: pix_out/out_valid 3 cycles after the accepted pixel closing a window; frame_done 1 cycle after a frame's last pixel.
// Backpressure: none; the pipeline free-runs and gaps in enable/in_valid become gaps in out_valid.
module conv3x3_engine #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int SHIFT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       in_valid,
    input  logic [7:0] row0,
    input  logic [7:0] row1,
    input  logic [7:0] row2,
    input  logic       coef_wr,
    input  logic [3:0] coef_addr,
    input  logic [7:0] coef_data,
    output logic [7:0] pix_out,
    output logic       out_valid,
    output logic       frame_done
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [7:0]         win_q [9];
    logic [7:0]         win_d [9];
    logic               vld1_q, vld1_d;
    logic signed [7:0]  coef_q [9];
    logic signed [7:0]  coef_d [9];
    logic signed [15:0] prod_q [9];
    logic signed [15:0] prod_d [9];
    logic               vld2_q, vld2_d;
    logic [7:0]         pix_q, pix_d;
    logic               vld3_q, vld3_d;
    logic               fd_q, fd_d;

    logic               accept;
    logic signed [19:0] acc_s;
    logic signed [19:0] shifted_s;
    logic signed [19:0] mag_s;

    assign accept = enable & in_valid;

    function automatic logic signed [15:0] mul8(input logic [7:0] p, input logic signed [7:0] c);
        return $signed({8'd0, p}) * $signed({{8{c[7]}}, c});
    endfunction

    // Window is kept in raster order: index r*3+c, c=2 is the newest column.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        vld1_d  = 1'b0;
        fd_d    = 1'b0;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = row0;
            win_d[5] = row1;
            win_d[8] = row2;
            vld1_d   = (state_q == ACTIVE);
            if (col_q == COL_LAST) begin
                col_d = '0;
                fd_d  = (row_q == ROW_LAST);
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (state_q == FILL && col_q == CW'(1)) begin
                state_d = ACTIVE;
            end else if (state_q == ACTIVE && col_q == COL_LAST) begin
                state_d = FILL;
            end
        end
    end

    always_comb begin
        coef_d = coef_q;
        if (coef_wr && (coef_addr < 4'd9)) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = mul8(win_q[k], coef_q[k]);
        end
        vld2_d = vld1_q;
    end

    // Nine 16-bit products need at most 20 bits signed before the shift.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < 9; k++) begin
            acc_s = acc_s + {{4{prod_q[k][15]}}, prod_q[k]};
        end
        shifted_s = acc_s >>> SHIFT;
        if (shifted_s[19]) begin
`ifdef CONV3X3_ABS_EN
            mag_s = -shifted_s;
`else
            mag_s = '0;
`endif
        end else begin
            mag_s = shifted_s;
        end
        pix_d  = (mag_s[19:8] != '0) ? 8'hFF : mag_s[7:0];
        vld3_d = vld2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            vld3_q  <= 1'b0;
            pix_q   <= '0;
            fd_q    <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k]  <= '0;
                prod_q[k] <= '0;
                coef_q[k] <= (k == 4) ? 8'sd1 : 8'sd0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vld1_q  <= vld1_d;
            vld2_q  <= vld2_d;
            vld3_q  <= vld3_d;
            pix_q   <= pix_d;
            fd_q    <= fd_d;
            win_q   <= win_d;
            prod_q  <= prod_d;
            coef_q  <= coef_d;
        end
    end

    assign pix_out    = pix_q;
    assign out_valid  = vld3_q;
    assign frame_done = fd_q;

endmodule
